// File: rtl/sr_latch_cmd_driver.sv
// sr_latch_cmd_driver
// Turns a one-bit set/reset request into a safe s/r/c waveform for a gated SR latch.
// The waveform has four phases: setup, enable strobe, hold, then a one-cycle done.
// Optional feature: define SR_READBACK_CHECK_EN to compare latch q/qn against the
// command on the last hold cycle and report the result on err alongside done.
// Without the macro, err is tied low and q/qn are ignored.
module sr_latch_cmd_driver #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_data,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic c,
  input  logic q,
  input  logic qn,
  output logic busy,
  output logic done,
  output logic err
);

  // A zero-length phase would break the waveform guarantees, so zero is promoted to one.
  localparam int SETUP_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int PULSE_EFF = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
  localparam int HOLD_EFF  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;

  // Each phase counter loads N-1 on entry and leaves the phase when it reaches 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_EFF - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cmd;

  // Command FSM. Every output is registered. s and r are only ever loaded as
  // complementary values or cleared together, so s&r can never be 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      c         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd       <= req_data;
            s         <= req_data;
            r         <= ~req_data;
            c         <= 1'b0;
            cnt       <= SETUP_LD;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            c     <= 1'b1;
            cnt   <= PULSE_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            c     <= 1'b0;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          s         <= 1'b0;
          r         <= 1'b0;
          c         <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef SR_READBACK_CHECK_EN
  // Samples the latch readback on the last hold cycle. The result is visible only
  // in the DONE cycle; err is cleared on every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == HOLD && cnt == '0) begin
      err <= (q != cmd) | (qn != ~cmd);
    end else begin
      err <= 1'b0;
    end
  end
`else
  // No readback check in this build. The feedback pins are deliberately left unused.
  logic unused_feedback;
  assign unused_feedback = q ^ qn;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_cmd_driver.sv
// Testbench for sr_latch_cmd_driver.
// Three instances with different phase lengths are used. One of them has zero
// lengths, which the design must promote to one cycle.
// A behavioural model tracks how many edges have passed since each accept
// ("age"). From the age it derives the expected s/r/c/busy/done/ready/err on
// every cycle. Directed sequences pin the model with literal expectations.
module tb_sr_latch_cmd_driver;

  localparam int N = 3;
  localparam int SA [N] = '{1, 0, 3};
  localparam int PA [N] = '{2, 1, 4};
  localparam int HA [N] = '{1, 0, 2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_data = '0;
  logic [N-1:0] stuck = '0;
  logic [N-1:0] req_ready, s, r, c, q, qn, busy, done, err;
  logic [N-1:0] q_lat = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    sr_latch_cmd_driver #(
      .SETUP_CYC(SA[gi]), .PULSE_CYC(PA[gi]), .HOLD_CYC(HA[gi]), .CNT_W(4)
    ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[gi]), .req_data(req_data[gi]),
      .req_ready(req_ready[gi]), .s(s[gi]), .r(r[gi]), .c(c[gi]),
      .q(q[gi]), .qn(qn[gi]), .busy(busy[gi]), .done(done[gi]), .err(err[gi])
    );
    assign q[gi]  = stuck[gi] ? 1'b0 : q_lat[gi];
    assign qn[gi] = ~q[gi];
  end

  function automatic int eff(input int x);
    return (x < 1) ? 1 : x;
  endfunction

  function automatic int total_len(input int i);
    return eff(SA[i]) + eff(PA[i]) + eff(HA[i]);
  endfunction

  // Gated SR latch: the output follows s/r while c is high.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (c[i]) begin
        if (s[i]) q_lat[i] <= 1'b1;
        else if (r[i]) q_lat[i] <= 1'b0;
      end
    end
  end

  // Reference model. age = 0 means no command has been seen yet.
  // age = k means k edges have passed since the accept (age 1 is the first setup cycle).
  // An age >= L+2 means idle, and a new request may be accepted.
  int   age [N];
  logic cmd_m [N];
  logic mm [N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        age[i] <= 0;
        mm[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((age[i] == 0 || age[i] >= total_len(i) + 2) && req_valid[i]) begin
          age[i]   <= 1;
          cmd_m[i] <= req_data[i];
        end else if (age[i] != 0 && age[i] < total_len(i) + 2) begin
          age[i] <= age[i] + 1;
        end
        if (age[i] == total_len(i))
          mm[i] <= (q[i] != cmd_m[i]) || (qn[i] != !cmd_m[i]);
      end
    end
  end

  // Expected output vector: {req_ready, busy, s, r, c, done, err}
  function automatic logic [6:0] expect_out(input int i);
    int   a, len, su, pu;
    logic act, bsy, dn, e;
    a   = age[i];
    len = total_len(i);
    su  = eff(SA[i]);
    pu  = eff(PA[i]);
    act = (a >= 1) && (a <= len);
    bsy = (a >= 1) && (a <= len + 1);
    dn  = (a == len + 1);
`ifdef SR_READBACK_CHECK_EN
    e = dn && mm[i];
`else
    e = 1'b0;
`endif
    return {!bsy, bsy, act && cmd_m[i] === 1'b1, act && cmd_m[i] === 1'b0,
            (a >= su + 1) && (a <= su + pu), dn, e};
  endfunction

  task automatic compare_all();
    logic [6:0] got, exp;
    for (int i = 0; i < N; i++) begin
      got = {req_ready[i], busy[i], s[i], r[i], c[i], done[i], err[i]};
      exp = expect_out(i);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cycle dut%0d age=%0d got{rdy,bsy,s,r,c,dn,err}=%b want=%b t=%0t",
                 i, age[i], got, exp, $time);
      end
    end
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // One cycle: compare on the falling edge, then move away from it before driving inputs.
  task automatic step();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  bit s_tab0 [6] = '{1, 1, 1, 1, 0, 0};
  bit c_tab0 [6] = '{0, 1, 1, 0, 0, 0};
  bit d_tab0 [6] = '{0, 0, 0, 0, 1, 0};
  bit y_tab0 [6] = '{0, 0, 0, 0, 0, 1};
  bit r_tab1 [5] = '{1, 1, 1, 0, 0};
  bit c_tab1 [5] = '{0, 1, 0, 0, 0};
  bit d_tab1 [5] = '{0, 0, 0, 1, 0};

  initial begin
    int  dcnt;
    bit  stuck_err;
    step();
    step();
    chk("reset_ready", req_ready[0], 1'b1);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_c", c[0], 1'b0);
    rst_n = 1'b1;
    step();

    // Set command on the default-timing instance.
    req_valid[0] = 1'b1; req_data[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req_valid[0] = 1'b0;
      chk($sformatf("set_s_T%0d", k), s[0], s_tab0[k-1]);
      chk($sformatf("set_r_T%0d", k), r[0], 1'b0);
      chk($sformatf("set_c_T%0d", k), c[0], c_tab0[k-1]);
      chk($sformatf("set_done_T%0d", k), done[0], d_tab0[k-1]);
      chk($sformatf("set_ready_T%0d", k), req_ready[0], y_tab0[k-1]);
    end

    // Reset command on the 1-cycle-pulse instance (zero lengths promoted to one).
    req_valid[1] = 1'b1; req_data[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) req_valid[1] = 1'b0;
      chk($sformatf("rst_cmd_r_T%0d", k), r[1], r_tab1[k-1]);
      chk($sformatf("rst_cmd_s_T%0d", k), s[1], 1'b0);
      chk($sformatf("rst_cmd_c_T%0d", k), c[1], c_tab1[k-1]);
      chk($sformatf("rst_cmd_done_T%0d", k), done[1], d_tab1[k-1]);
    end

    // Asynchronous reset asserted in the middle of STROBE.
    req_valid[0] = 1'b1; req_data[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    step();
    chk("pre_reset_c", c[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_s", s[0], 1'b0);
    chk("async_r", r[0], 1'b0);
    chk("async_c", c[0], 1'b0);
    chk("async_busy", busy[0], 1'b0);
    chk("async_ready", req_ready[0], 1'b1);
    step();
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done[0]) dcnt++;
    end
    chk_int("no_done_after_reset", dcnt, 0);

    // Back-to-back with req_valid held: set, then reset; the second accept ends the idle cycle.
    req_valid[0] = 1'b1; req_data[0] = 1'b1;
    dcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) req_data[0] = 1'b0;
      if (done[0]) dcnt++;
      if (k == 6) chk("b2b_idle_gap_busy", busy[0], 1'b0);
      if (k == 7) chk("b2b_second_r", r[0], 1'b1);
    end
    req_valid[0] = 1'b0;
    chk_int("b2b_done_count", dcnt, 2);
    step();

    // Readback with q stuck at 0, then with a healthy latch.
`ifdef SR_READBACK_CHECK_EN
    stuck_err = 1'b1;
`else
    stuck_err = 1'b0;
`endif
    for (int pass = 0; pass < 2; pass++) begin
      stuck[0] = (pass == 0);
      req_valid[0] = 1'b1; req_data[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        step();
        if (k == 1) req_valid[0] = 1'b0;
        if (k == 5) begin
          chk($sformatf("rb_done_p%0d", pass), done[0], 1'b1);
          chk($sformatf("rb_err_p%0d", pass), err[0], (pass == 0) ? stuck_err : 1'b0);
        end
      end
    end
    stuck[0] = 1'b0;

    // Randomised traffic on all instances, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_data[i]  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 49) == 0) stuck[i] = ~stuck[i];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
